// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline control blocks.
//   - opcode constants for the instruction classes the decoder recognises
//   - forwarding select encoding for the EX-stage operand muxes
//   - stage_meta: destination-register metadata carried by a pipeline stage
//   - writes_reg(): "does this stage write register r" qualification
package core_pkg;

    localparam int RA_W_PKG = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [RA_W_PKG-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } stage_meta;

    // x0 is hardwired to zero, so a stage targeting it is never a writer.
    function automatic logic writes_reg(input stage_meta m, input logic [RA_W_PKG-1:0] r);
        return m.valid & m.reg_write & (m.rd != '0) & (m.rd == r);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding priority selector for one EX-stage ALU operand.
// Evaluated for the instruction about to enter EX, so "mem_meta" is the
// stage that will sit in MEM next cycle and "wb_meta" the one that will be
// in WB.
//   src      in  source register read by the instruction
//   uses     in  the instruction actually reads src
//   mem_meta in  metadata of the stage that will be in MEM
//   wb_meta  in  metadata of the stage that will be in WB
//   sel      out FWD_RF / FWD_WB / FWD_MEM
module fwd_sel
    import core_pkg::*;
(
    input  logic [RA_W_PKG-1:0] src,
    input  logic                uses,
    input  stage_meta           mem_meta,
    input  stage_meta           wb_meta,
    output logic [1:0]          sel
);

    // MEM is checked first: the youngest writer holds the newest value.
    always_comb begin
        sel = FWD_RF;
        if (uses) begin
            if (writes_reg(mem_meta, src)) begin
                sel = FWD_MEM;
            end else if (writes_reg(wb_meta, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core. Keeps a shadow
// copy of EX/MEM/WB destination metadata, raises a one-cycle load-use
// stall, squashes the ID instruction on a taken branch and produces
// registered forwarding selects for the EX operands.
//   clk, rst_n            clock, async active-low reset
//   id_*                  decoded fields of the instruction in ID
//   ex_flush              taken branch/jump resolved in EX
//   stall                 hold PC and IF/ID, bubble into EX (combinational)
//   fwd_a, fwd_b          registered EX operand source selects
//   ex_valid              EX holds a live instruction
//   stall_cnt             saturating count of stall cycles
module hazard_fwd_ctrl
    import core_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    // The stage metadata struct is sized by the package.
    if (RA_W != RA_W_PKG) begin : g_bad_ra_w
        $error("hazard_fwd_ctrl: RA_W must equal core_pkg::RA_W_PKG");
    end

    stage_meta       ex_q, mem_q, wb_q;
    logic [RA_W-1:0] ex_rs1_q, ex_rs2_q;

    logic            ex_valid_next;
    stage_meta       ex_next;
    logic [1:0]      sel_a, sel_b;
    logic            load_hit;

    // Load in EX whose result the ID instruction needs next cycle: the
    // data only exists after MEM, so ID must wait one cycle.
    always_comb begin
        load_hit = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                   ((id_uses_rs1 & (ex_q.rd == id_rs1)) |
                    (id_uses_rs2 & (ex_q.rd == id_rs2)));
        stall    = id_valid & ~ex_flush & load_hit;
    end

    always_comb begin
        ex_valid_next     = id_valid & ~stall & ~ex_flush;
        ex_next           = '0;
        ex_next.valid     = ex_valid_next;
        ex_next.rd        = id_rd;
        ex_next.reg_write = id_reg_write;
        ex_next.mem_read  = id_mem_read;
    end

    // Current EX moves to MEM and current MEM moves to WB on the same edge
    // the ID instruction enters EX.
    fwd_sel u_fwd_sel_a (
        .src      (id_rs1),
        .uses     (id_uses_rs1),
        .mem_meta (ex_q),
        .wb_meta  (mem_q),
        .sel      (sel_a)
    );

    fwd_sel u_fwd_sel_b (
        .src      (id_rs2),
        .uses     (id_uses_rs2),
        .mem_meta (ex_q),
        .wb_meta  (mem_q),
        .sel      (sel_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
        end else begin
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q     <= ex_next;
            ex_rs1_q <= id_rs1;
            ex_rs2_q <= id_rs2;
            // A bubble carries no operands, so its selects are parked at RF.
            fwd_a    <= ex_valid_next ? sel_a : FWD_RF;
            fwd_b    <= ex_valid_next ? sel_b : FWD_RF;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_valid = ex_q.valid;

    // Invariants tying the registered selects back to the shadow stages:
    // a MEM forward is always an ALU result (never a load), and any
    // selected source really does write the register EX is reading.
    a_fwd_a_mem: assert property (@(posedge clk) disable iff (!rst_n)
        (fwd_a == FWD_MEM) |-> (writes_reg(mem_q, ex_rs1_q) && !mem_q.mem_read));
    a_fwd_b_mem: assert property (@(posedge clk) disable iff (!rst_n)
        (fwd_b == FWD_MEM) |-> (writes_reg(mem_q, ex_rs2_q) && !mem_q.mem_read));
    a_fwd_a_wb: assert property (@(posedge clk) disable iff (!rst_n)
        (fwd_a == FWD_WB) |-> writes_reg(wb_q, ex_rs1_q));
    a_fwd_b_wb: assert property (@(posedge clk) disable iff (!rst_n)
        (fwd_b == FWD_WB) |-> writes_reg(wb_q, ex_rs2_q));
    a_load_writes: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_q.valid && wb_q.mem_read) |-> wb_q.reg_write);

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It sits beside the main decoder.
- Tracks destination-register metadata for the EX, MEM and WB stages in its own shadow pipeline.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Produces registered ALU operand forwarding selects for the EX stage and squashes stages on a taken branch.

Parameters:
- RA_W, 5, register-address width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  RA_W  ID source register 1
- id_rs2  in  RA_W  ID source register 2
- id_uses_rs1  in  1  instruction reads rs1 (R, I, L, S types)
- id_uses_rs2  in  1  instruction reads rs2 (R, S types)
- id_rd  in  RA_W  ID destination register
- id_reg_write  in  1  RegWrite from the decoder
- id_mem_read  in  1  MemRead from the decoder
- ex_flush  in  1  taken branch/jump resolved in EX
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- fwd_a  out  2  EX operand A source: 00 regfile, 01 WB result, 10 MEM ALU result
- fwd_b  out  2  EX operand B source, same encoding as fwd_a
- ex_valid  out  1  EX stage holds a live instruction (0 = bubble)
- stall_cnt  out  CNT_W  count of stall cycles, saturating

Behaviour:

Shadow stages:
- Each of EX, MEM and WB holds: valid, rd, reg_write, mem_read, plus EX holds rs1 and rs2.
- Advance every cycle: WB<=MEM, MEM<=EX.
- EX <= ID fields, with valid = id_valid & ~stall & ~ex_flush.

Writer qualification:
- A stage "writes r" when valid & reg_write & rd!=0 & rd==r.
- x0 never matches: it never causes a stall or a forward.

Load-use stall (combinational from current state):
- stall = id_valid & ~ex_flush & EX.valid & EX.mem_read & EX.rd!=0 & ((id_uses_rs1 & EX.rd==id_rs1) | (id_uses_rs2 & EX.rd==id_rs2)).
- Stall lasts exactly one cycle. The next cycle the load is in MEM, the EX bubble is not a writer, and stall deasserts.

Flush:
- ex_flush forces stall=0 (flush wins over stall).
- Next cycle EX.valid=0, which discards the ID instruction.
- MEM/WB advance normally; the branch itself proceeds.

Forwarding (registered, computed one cycle ahead for the instruction entering EX):
- fwd_a next = 10 if the current EX stage writes id_rs1 (it will be in MEM).
- Else 01 if the current MEM stage writes id_rs1 (it will be in WB).
- Else 00.
- MEM has priority over WB (youngest writer wins).
- fwd_b is identical using id_rs2.
- A source not used (id_uses_rsX=0) gives 00.
- When the EX load-in-EX match applies, stall is asserted, so the bubble enters EX with fwd 00.
- On the post-stall cycle the instruction re-enters from ID and picks up 01/10 normally.
- When EX next valid is 0 (bubble, flush, or id_valid=0), fwd_a and fwd_b load 00.
- A load in MEM forwarding to EX is never selected (guaranteed by the stall); the MEM source is the ALU result only.

Counter:
- stall_cnt increments by 1 on each cycle where stall=1.
- Saturates at all-ones.

Reset (async, any time including mid-stall):
- All shadow valids are 0.
- fwd_a=fwd_b=00, ex_valid=0, stall_cnt=0.
- stall=0 (follows from EX.valid=0).
- First instruction after deassertion sees no hazards.

Decomposition:
- Shared package core_pkg:
  - opcode constants (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011)
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - a stage_meta struct {valid, rd, reg_write, mem_read}
- One sub-module: fwd_sel, a combinational priority selector (src reg, uses flag, MEM-next meta, WB-next meta -> 2-bit select), instantiated twice for A and B.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release, then issue add x3,x1,x2 -> stall=0, fwd_a=fwd_b=00, stall_cnt=0.
- EX->MEM forward: add x5,x1,x2 then add x6,x5,x5 back-to-back -> second instruction in EX with fwd_a=fwd_b=10, no stall.
- WB forward and priority:
  - add x7 ; nop ; add x8,x7,x0 -> fwd_a=01.
  - add x7 ; add x7 ; add x9,x7,x7 -> fwd_a=fwd_b=10 (youngest wins).
- Load-use: lw x4,0(x1) then add x5,x4,x2 -> stall=1 for exactly one cycle, ex_valid=0 next cycle, add then enters EX with fwd_a=01, stall_cnt=1.
- x0 and unused sources:
  - addi x0,... then add x1,x0,x0 -> no forward.
  - lw x4 then addi x6,x3,1 with id_rs2=4 and id_uses_rs2=0 -> no stall.
- Flush vs stall: lw x4 in EX, dependent add in ID, ex_flush=1 in the same cycle -> stall=0, next cycle ex_valid=0, stall_cnt unchanged. Also assert rst_n=0 during a stall cycle -> all outputs return to reset values immediately.
